// File: rtl/vga_sync_gen.sv
// VGA timing generator: pixel-rate divider, H/V position counters and decoded
// sync, visible-area, pixel strobe and start-of-frame outputs.
//
// state    | meaning
// ST_START | first pixel tick after reset: present (0,0) without advancing
// ST_RUN   | counters advance on every pixel tick
module vga_sync_gen #(
    parameter int unsigned CLK_DIV  = 2,
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33,
    parameter bit          SYNC_POL = 1'b0
) (
    input  logic       Clk,
    input  logic       reset,
    output logic [9:0] Posx,
    output logic [9:0] Posy,
    output logic       hsync,
    output logic       vsync,
    output logic       video_on,
    output logic       pixel_tick,
    output logic       frame_start
);
    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CLK_DIV - 1);
    localparam logic [9:0] X_MAX    = 10'(H_TOTAL - 1);
    localparam logic [9:0] Y_MAX    = 10'(V_TOTAL - 1);
    localparam logic [9:0] X_VIS    = 10'(H_ACTIVE);
    localparam logic [9:0] Y_VIS    = 10'(V_ACTIVE);
    localparam logic [9:0] HS_FIRST = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_LAST  = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [9:0] VS_FIRST = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_LAST  = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

    typedef enum logic {ST_START, ST_RUN} state_t;

    state_t           state, state_nx;
    logic [DIV_W-1:0] divider;
    logic             tick_en;
    logic [9:0]       x_nx, y_nx;
    logic             hs_nx, vs_nx, vo_nx, fs_nx;

    assign tick_en = (divider == DIV_MAX);

    always_ff @(posedge Clk) begin
        if (reset || tick_en) divider <= '0;
        else                  divider <= divider + 1'b1;
    end

    always_ff @(posedge Clk) begin
        if (reset) state <= ST_START;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        x_nx     = Posx;
        y_nx     = Posy;
        if (tick_en) begin
            case (state)
                ST_START: begin
                    x_nx     = '0;
                    y_nx     = '0;
                    state_nx = ST_RUN;
                end
                ST_RUN: begin
                    if (Posx == X_MAX) begin
                        x_nx = '0;
                        y_nx = (Posy == Y_MAX) ? 10'd0 : Posy + 10'd1;
                    end else begin
                        x_nx = Posx + 10'd1;
                    end
                end
            endcase
        end
        // Decode from the next position so outputs line up with Posx/Posy.
        hs_nx = (x_nx >= HS_FIRST && x_nx <= HS_LAST) ? SYNC_POL : ~SYNC_POL;
        vs_nx = (y_nx >= VS_FIRST && y_nx <= VS_LAST) ? SYNC_POL : ~SYNC_POL;
        vo_nx = (x_nx < X_VIS) && (y_nx < Y_VIS);
        fs_nx = tick_en && (x_nx == 10'd0) && (y_nx == 10'd0);
    end

    always_ff @(posedge Clk) begin
        if (reset) begin
            Posx        <= '0;
            Posy        <= '0;
            hsync       <= ~SYNC_POL;
            vsync       <= ~SYNC_POL;
            video_on    <= 1'b0;
            pixel_tick  <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            pixel_tick  <= tick_en;
            frame_start <= fs_nx;
            if (tick_en) begin
                Posx     <= x_nx;
                Posy     <= y_nx;
                hsync    <= hs_nx;
                vsync    <= vs_nx;
                video_on <= vo_nx;
            end
        end
    end
endmodule

// File: doc/vga_sync_gen.md
Name: vga_sync_gen

Overview:
Timing generator for the 640x480 @ 60 Hz VGA path. It divides the system clock down to the pixel rate and runs horizontal and vertical pixel counters. It drives Posx/Posy to the character-pattern memory and hsync/vsync to the monitor connector. It also provides video_on, a pixel strobe and a start-of-frame pulse for downstream logic.

Parameters:
CLK_DIV, 2, system Clk cycles per pixel (50 MHz -> 25 MHz); legal range >= 1
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, hsync pulse width (pixels)
H_BP, 48, horizontal back porch (pixels)
V_ACTIVE, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vsync pulse width (lines)
V_BP, 33, vertical back porch (lines)
SYNC_POL, 0, asserted level of hsync/vsync (0 = active-low)

Ports:
Clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high
Posx  output  10  horizontal pixel counter, 0..H_TOTAL-1
Posy  output  10  vertical line counter, 0..V_TOTAL-1
hsync  output  1  horizontal sync, level per SYNC_POL
vsync  output  1  vertical sync, level per SYNC_POL
video_on  output  1  1 when (Posx,Posy) is inside the visible area
pixel_tick  output  1  one-Clk strobe; new Posx/Posy/syncs valid this cycle
frame_start  output  1  one-Clk strobe coincident with pixel_tick presenting (0,0)

Behaviour:
- Derived constants: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525).
- Reset, synchronous and active-high, has priority over all other logic and applies on any cycle, including mid-frame. Reset values: divider=0, Posx=0, Posy=0, hsync=vsync=!SYNC_POL, video_on=0, pixel_tick=0, frame_start=0, started=0.
- Divider: counts 0..CLK_DIV-1 and wraps. The internal enable tick_en=1 when divider==CLK_DIV-1. With CLK_DIV=1, tick_en=1 on every cycle.
- All outputs are registered. They change only on edges where tick_en=1, except pixel_tick and frame_start, which are registered every cycle.
- pixel_tick <= tick_en. Its period is exactly CLK_DIV cycles. With CLK_DIV=1 it is constantly 1 after the first post-reset edge.
- Start-up (started=0) on the first tick_en after reset:
  - Posx and Posy stay at 0.
  - Decoded outputs are loaded for (0,0): video_on=1, syncs inactive.
  - started is set to 1 and frame_start is pulsed.
  - Pixel (0,0) of the first frame is therefore presented, not skipped.
- Run (started=1) on each tick_en:
  - Posx == H_TOTAL-1: Posx -> 0 and Posy advances. Posy == V_TOTAL-1 wraps to 0; otherwise Posy -> Posy+1.
  - Otherwise Posx -> Posx+1 and Posy holds.
- Decode outputs are computed from the next counter values, so they align with Posx/Posy in the same cycle:
  - hsync = SYNC_POL when H_ACTIVE+H_FP <= Posx <= H_ACTIVE+H_FP+H_SYNC-1 (656..751); otherwise inverted.
  - vsync = SYNC_POL when V_ACTIVE+V_FP <= Posy <= V_ACTIVE+V_FP+V_SYNC-1 (490..491); otherwise inverted. vsync changes only at line boundaries.
  - video_on = (Posx < H_ACTIVE) && (Posy < V_ACTIVE).
  - frame_start <= tick_en && next (Posx,Posy) == (0,0). In run mode this fires on the (H_TOTAL-1,V_TOTAL-1) -> (0,0) wrap.
- Counter values outside their range must never appear. Width is 10 bits, with no overflow for the default totals.
- Reset mid-frame: on the next cycle all outputs equal their reset values. The start-up sequence then repeats.

Test Plan:
- Reset released with CLK_DIV=2 -> pixel_tick first high 2 cycles later. Posx=0, Posy=0, video_on=1, frame_start=1 on that cycle. Next tick gives Posx=1 and frame_start=0.
- Run one line -> hsync goes low exactly when Posx becomes 656 and high when Posx becomes 752. video_on falls when Posx becomes 640.
- Line wrap -> at Posx 799 -> 0, Posy increments 0 -> 1 in the same cycle. Posx never reads 800.
- Full frame -> vsync low only for Posy 490..491. (799,524) -> (0,0) with frame_start=1. Exactly 420000 pixel_ticks between frame_start pulses.
- Reset asserted at Posx=300, Posy=200 -> next cycle Posx=0, Posy=0, hsync=vsync=1, video_on=0, pixel_tick=0. Start-up repeats after release.
- CLK_DIV=1, SYNC_POL=1 -> pixel_tick constantly 1 after start-up, hsync high for Posx 656..751, frame period 420000 Clk cycles.
